// File: rtl/mem_rr_pkg.sv
// Shared types and constants for the round-robin memory controller.
//   MEM_AW / MEM_DW : memory address / data width (16x8 register memory)
//   mem_req_t       : one memory access (write flag, address, write data)
//   owner_e         : which requester an access belongs to
//   state_e         : controller states (ST_INIT only used with MEM_RR_CTRL_INIT_EN)
package mem_rr_pkg;

  localparam int unsigned MEM_AW = 4;
  localparam int unsigned MEM_DW = 8;

  typedef struct packed {
    logic              we;
    logic [MEM_AW-1:0] adr;
    logic [MEM_DW-1:0] wdat;
  } mem_req_t;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/mem_rr_ctrl_rr_pick2.sv
// rr_pick2: two-input round-robin picker.
//   clk, rst : clock, synchronous active-high reset
//   req[1:0] : request lines (bit 0 = A, bit 1 = B)
//   advance  : a grant was taken this cycle; update the last-grant pointer
//   gnt[1:0] : one-hot grant, combinational from req and the pointer
module rr_pick2
  import mem_rr_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  owner_e last_q;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_q == OWN_B) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Reset to B so that A wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= OWN_B;
    end else if (advance) begin
      last_q <= gnt[1] ? OWN_B : OWN_A;
    end
  end

endmodule

// File: rtl/mem_rr_ctrl.sv
// mem_rr_ctrl: shares a single-port 16x8 register memory (registered read
// address, read data one cycle later) between requesters A and B.
// Optional build macro: MEM_RR_CTRL_INIT_EN -- after reset, clear all 16
// memory words to zero (busy high) before accepting requests.
//   clk, rst            : clock, synchronous active-high reset
//   x_valid/x_ready     : request handshake per requester (ready is the grant)
//   x_we/x_adr/x_wdat   : request payload
//   x_rvalid/x_rdat     : one-cycle read response (rdat is 0 when rvalid low)
//   mem_adr/mem_dat_w/mem_we/mem_dat_r : memory port
//   busy                : controller not accepting requests (INIT)
// AW/DW must match MEM_AW/MEM_DW of mem_rr_pkg.
module mem_rr_ctrl
  import mem_rr_pkg::*;
#(
  parameter int unsigned AW = MEM_AW,
  parameter int unsigned DW = MEM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic          a_we,
  input  logic [AW-1:0] a_adr,
  input  logic [DW-1:0] a_wdat,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdat,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic          b_we,
  input  logic [AW-1:0] b_adr,
  input  logic [DW-1:0] b_wdat,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdat,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_dat_w,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dat_r,
  output logic          busy
);

  state_e     state_q, state_d;
  logic       run_en;
  logic [1:0] req;
  logic [1:0] gnt;
  mem_req_t   a_req, b_req, mem_req;
  logic       rd_q;
  owner_e     own_q;
`ifdef MEM_RR_CTRL_INIT_EN
  logic [AW-1:0] cnt_q, cnt_d;
`endif

  // Requests are only eligible in RUN and never while reset is asserted.
  assign run_en = !rst && (state_q == ST_RUN);
  assign req    = {b_valid, a_valid} & {2{run_en}};

  rr_pick2 u_pick (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (|gnt),
    .gnt     (gnt)
  );

  assign a_ready = gnt[0];
  assign b_ready = gnt[1];

  assign a_req = '{we: a_we, adr: a_adr, wdat: a_wdat};
  assign b_req = '{we: b_we, adr: b_adr, wdat: b_wdat};

  // State register (and clear counter when the INIT sweep is built in).
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef MEM_RR_CTRL_INIT_EN
      state_q <= ST_INIT;
      cnt_q   <= '0;
`else
      state_q <= ST_RUN;
`endif
    end else begin
      state_q <= state_d;
`ifdef MEM_RR_CTRL_INIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next state and memory drive: INIT sweeps zeros, RUN forwards the grant.
  always_comb begin
    state_d = state_q;
    mem_req = '0;
`ifdef MEM_RR_CTRL_INIT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_INIT: begin
`ifdef MEM_RR_CTRL_INIT_EN
        if (!rst) begin
          mem_req.we  = 1'b1;
          mem_req.adr = cnt_q;
          cnt_d       = cnt_q + AW'(1);
          if (&cnt_q) begin
            state_d = ST_RUN;
          end
        end
`else
        state_d = ST_RUN;
`endif
      end
      ST_RUN: begin
        if (gnt[0]) begin
          mem_req = a_req;
        end else if (gnt[1]) begin
          mem_req = b_req;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign mem_we    = mem_req.we;
  assign mem_adr   = mem_req.adr;
  assign mem_dat_w = mem_req.wdat;
  assign busy      = (state_q == ST_INIT);

  // Response pipeline: read flag and owner of the access granted this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= 1'b0;
      own_q <= OWN_A;
    end else begin
      rd_q  <= (gnt[0] && !a_we) || (gnt[1] && !b_we);
      own_q <= gnt[1] ? OWN_B : OWN_A;
    end
  end

  assign a_rvalid = rd_q && (own_q == OWN_A);
  assign b_rvalid = rd_q && (own_q == OWN_B);
  assign a_rdat   = a_rvalid ? mem_dat_r : '0;
  assign b_rdat   = b_rvalid ? mem_dat_r : '0;

endmodule

// File: tb/tb_mem_rr_ctrl.sv
// Testbench for mem_rr_ctrl: external 16x8 memory with registered read
// address, directed scenarios followed by random traffic, all compared with
// a transaction-level reference model.
module tb_mem_rr_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
`ifdef MEM_RR_CTRL_INIT_EN
  localparam int INIT_CYCLES = 16;
`else
  localparam int INIT_CYCLES = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, a_ready, a_we, a_rvalid;
  logic [AW-1:0] a_adr;
  logic [DW-1:0] a_wdat, a_rdat;
  logic          b_valid, b_ready, b_we, b_rvalid;
  logic [AW-1:0] b_adr;
  logic [DW-1:0] b_wdat, b_rdat;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_dat_w, mem_dat_r;
  logic          mem_we, busy;

  always #5 clk = ~clk;

  mem_rr_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_adr(a_adr),
    .a_wdat(a_wdat), .a_rvalid(a_rvalid), .a_rdat(a_rdat),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_adr(b_adr),
    .b_wdat(b_wdat), .b_rvalid(b_rvalid), .b_rdat(b_rdat),
    .mem_adr(mem_adr), .mem_dat_w(mem_dat_w), .mem_we(mem_we),
    .mem_dat_r(mem_dat_r), .busy(busy)
  );

  // External single-port memory: synchronous write, registered read address.
  logic [DW-1:0] mem_arr [16];
  logic [AW-1:0] mem_adr_q;
  always @(posedge clk) begin
    if (mem_we) mem_arr[mem_adr] <= mem_dat_w;
    mem_adr_q <= mem_adr;
  end
  assign mem_dat_r = mem_arr[mem_adr_q];

  // Reference model state.
  logic [DW-1:0] ref_mem [16];
  bit            ref_last_b;
  int            init_left;
  bit            exp_a_rv, exp_b_rv;
  logic [DW-1:0] exp_a_rd, exp_b_rd;
  bit            mod_ga, mod_gb;
  logic          obs_a_rdy, obs_b_rdy;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check one cycle against the model, then advance model and clock.
  task automatic tick();
    bit            en;
    logic [AW-1:0] iadr;
    #1;
    en     = !rst && (init_left == 0);
    mod_ga = en && a_valid && (!b_valid || ref_last_b);
    mod_gb = en && b_valid && !mod_ga;
    iadr   = AW'(16 - init_left);
    chk("a_ready", a_ready, mod_ga);
    chk("b_ready", b_ready, mod_gb);
    chk("busy", busy, init_left != 0);
    if (!rst && init_left != 0) begin
      chk("init_we", mem_we, 1);
      chk("init_adr", mem_adr, iadr);
      chk("init_dat", mem_dat_w, 0);
    end else if (mod_ga) begin
      chk("mem_we_a", mem_we, a_we);
      chk("mem_adr_a", mem_adr, a_adr);
      chk("mem_dat_a", mem_dat_w, a_wdat);
    end else if (mod_gb) begin
      chk("mem_we_b", mem_we, b_we);
      chk("mem_adr_b", mem_adr, b_adr);
      chk("mem_dat_b", mem_dat_w, b_wdat);
    end else begin
      chk("idle_we", mem_we, 0);
      chk("idle_adr", mem_adr, 0);
      chk("idle_dat", mem_dat_w, 0);
    end
    chk("a_rvalid", a_rvalid, exp_a_rv);
    chk("a_rdat", a_rdat, exp_a_rd);
    chk("b_rvalid", b_rvalid, exp_b_rv);
    chk("b_rdat", b_rdat, exp_b_rd);
    obs_a_rdy = a_ready;
    obs_b_rdy = b_ready;
    exp_a_rv = 0; exp_b_rv = 0; exp_a_rd = '0; exp_b_rd = '0;
    if (rst) begin
      ref_last_b = 1;
      init_left  = INIT_CYCLES;
    end else if (init_left != 0) begin
      ref_mem[iadr] = '0;
      init_left--;
    end else if (mod_ga) begin
      ref_last_b = 0;
      if (a_we) ref_mem[a_adr] = a_wdat;
      else begin exp_a_rv = 1; exp_a_rd = ref_mem[a_adr]; end
    end else if (mod_gb) begin
      ref_last_b = 1;
      if (b_we) ref_mem[b_adr] = b_wdat;
      else begin exp_b_rv = 1; exp_b_rd = ref_mem[b_adr]; end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] image [16];
    image = '{8'h90, 8'hB3, 8'h11, 8'hFE, 8'h22, 8'h33, 8'h44, 8'h5D,
              8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    for (int i = 0; i < 16; i++) begin
      mem_arr[i] = image[i];
      ref_mem[i] = image[i];
    end
    mem_adr_q = '0;
    rst = 1'b1;
    a_valid = 0; a_we = 0; a_adr = '0; a_wdat = '0;
    b_valid = 0; b_we = 0; b_adr = '0; b_wdat = '0;
    ref_last_b = 1; init_left = INIT_CYCLES;
    exp_a_rv = 0; exp_b_rv = 0; exp_a_rd = '0; exp_b_rd = '0;
    mod_ga = 0; mod_gb = 0;
    @(posedge clk);
    #1;
    tick();
    tick();
    rst = 1'b0;

`ifdef MEM_RR_CTRL_INIT_EN
    // Clear sweep, then a read of address 3 sees zero.
    chk("init_busy_start", busy, 1);
    repeat (16) tick();
    chk("init_busy_end", busy, 0);
    a_valid = 1; a_we = 0; a_adr = 4'd3;
    tick();
    chk("init_rd_grant", obs_a_rdy, 1);
    a_valid = 0;
    chk("init_rd_rv", a_rvalid, 1);
    chk("init_rd3", a_rdat, 8'h00);
    tick();
`else
    // Tie straight after reset: A first, then B.
    a_valid = 1; a_we = 0; a_adr = 4'd0;
    b_valid = 1; b_we = 0; b_adr = 4'd1;
    tick();
    chk("tie_a_first", obs_a_rdy, 1);
    a_valid = 0;
    chk("tie_a_rdat", a_rdat, 8'h90);
    tick();
    chk("tie_b_second", obs_b_rdy, 1);
    b_valid = 0;
    chk("tie_b_rdat", b_rdat, 8'hB3);
    chk("tie_no_overlap", a_rvalid, 0);
    tick();
    // Single A read of address 3.
    a_valid = 1; a_adr = 4'd3;
    tick();
    chk("rd3_grant", obs_a_rdy, 1);
    a_valid = 0;
    chk("rd3_rdat", a_rdat, 8'hFE);
    chk("rd3_b_rv", b_rvalid, 0);
    tick();
    // B writes 7, A reads 7 on the next cycle.
    b_valid = 1; b_we = 1; b_adr = 4'd7; b_wdat = 8'h5C;
    tick();
    b_valid = 0; b_we = 0;
    a_valid = 1; a_adr = 4'd7;
    tick();
    a_valid = 0;
    chk("raw_rdat", a_rdat, 8'h5C);
    tick();
    // Single B read so A owns the next tie, then six contended cycles.
    b_valid = 1; b_adr = 4'd2;
    tick();
    b_valid = 0;
    tick();
    a_valid = 1; a_adr = 4'd5; b_valid = 1; b_adr = 4'd6;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("alternate", obs_a_rdy, (i % 2) == 0);
    end
    a_valid = 0; b_valid = 0;
    tick();
    tick();
    // Read presented during reset is dropped; A wins the first tie after.
    a_valid = 1; a_adr = 4'd3; rst = 1;
    tick();
    chk("rst_no_grant", obs_a_rdy, 0);
    chk("rst_no_rv", a_rvalid, 0);
    rst = 0; b_valid = 1; b_adr = 4'd4;
    tick();
    chk("rst_a_tie", obs_a_rdy, 1);
    a_valid = 0;
    tick();
    b_valid = 0;
    tick();
`endif

    // Random traffic; a pending request holds until the model grants it.
    for (int n = 0; n < 400; n++) begin
      if (!a_valid || mod_ga) begin
        a_valid = ($urandom_range(0, 9) < 6);
        a_we    = 1'($urandom_range(0, 1));
        a_adr   = AW'($urandom_range(0, 15));
        a_wdat  = DW'($urandom);
      end
      if (!b_valid || mod_gb) begin
        b_valid = ($urandom_range(0, 9) < 6);
        b_we    = 1'($urandom_range(0, 1));
        b_adr   = AW'($urandom_range(0, 15));
        b_wdat  = DW'($urandom);
      end
      rst = ($urandom_range(0, 59) == 0);
      tick();
    end
    rst = 0; a_valid = 0; b_valid = 0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
